// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Purpose  : Single-port framebuffer arbiter: scanout reads, then a held UART write, then clear sweep.
// Revision : 1.0  initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 15,
    parameter int ACTIVE_HORI = 640,
    parameter int ACTIVE_VERT = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_tick,
    input  logic [9:0]        hori_cnt,
    input  logic [9:0]        vert_cnt,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pixel_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              de_out,
    output logic [7:0]        drop_cnt
);

    localparam logic [ADDR_W-1:0] CELLS     = ADDR_W'(FB_W * FB_H);
    localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(FB_W * FB_H - 1);
    localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(FB_W);
    localparam logic [9:0]        H_LIMIT   = 10'(ACTIVE_HORI);
    localparam logic [9:0]        V_LIMIT   = 10'(ACTIVE_VERT);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              tick_d;
    logic              tick_dd;
    logic              active;
    logic              slot_read;
    logic [ADDR_W-1:0] cell_row;
    logic [ADDR_W-1:0] cell_col;
    logic [ADDR_W-1:0] rd_addr;
    logic              de1;
    logic              hs1;
    logic              vs1;

    logic              hold_valid;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_fill;

    logic              wr_accept;
    logic              wr_oob;
    logic              clr_take;
    logic              hold_commit;
    logic              sweep_wr;

    // The counters have already advanced when tick_d is high, so the slot reads the new position.
    assign active    = (hori_cnt < H_LIMIT) && (vert_cnt < V_LIMIT);
    assign slot_read = tick_d && active;
    assign cell_row  = ADDR_W'(vert_cnt >> SCALE_SHIFT);
    assign cell_col  = ADDR_W'(hori_cnt >> SCALE_SHIFT);
    assign rd_addr   = cell_row * ROW_PITCH + cell_col;

    assign wr_ready  = (state == ST_IDLE) && !hold_valid;
    assign wr_accept = wr_valid && wr_ready;
    assign wr_oob    = (wr_addr >= CELLS);
    assign clr_take  = (state == ST_IDLE) && clr_req;
    assign clr_busy  = (state == ST_CLEAR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ram_addr    = '0;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        hold_commit = 1'b0;
        sweep_wr    = 1'b0;

        if (slot_read) begin
            ram_addr = rd_addr;
        end else if (hold_valid) begin
            ram_we      = 1'b1;
            ram_addr    = hold_addr;
            ram_wdata   = hold_data;
            hold_commit = 1'b1;
        end else if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = clr_addr;
            ram_wdata = clr_fill;
            sweep_wr  = 1'b1;
            if (clr_addr == CELL_LAST) begin
                state_nxt = ST_IDLE;
            end
        end

        if (clr_take) begin
            state_nxt = ST_CLEAR;
        end
    end

    // Accept and commit never coincide because wr_ready requires an empty hold register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
            drop_cnt   <= '0;
        end else begin
            if (hold_commit) begin
                hold_valid <= 1'b0;
            end
            if (wr_accept) begin
                if (wr_oob) begin
                    if (drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                end else begin
                    hold_valid <= 1'b1;
                    hold_addr  <= wr_addr;
                    hold_data  <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_addr <= '0;
            clr_fill <= '0;
        end else if (clr_take) begin
            clr_addr <= '0;
            clr_fill <= clr_color;
        end else if (sweep_wr) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    // Two-stage video pipe: stage 1 at the slot edge, stage 2 when the RAM word is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_d    <= 1'b0;
            tick_dd   <= 1'b0;
            de1       <= 1'b0;
            hs1       <= 1'b1;
            vs1       <= 1'b1;
            pixel_out <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            de_out    <= 1'b0;
        end else begin
            tick_d  <= pixel_tick;
            tick_dd <= tick_d;
            if (tick_d) begin
                de1 <= active;
                hs1 <= hsync_in;
                vs1 <= vsync_in;
            end
            if (tick_dd) begin
                pixel_out <= de1 ? ram_rdata : '0;
                hsync_out <= hs1;
                vsync_out <= vs1;
                de_out    <= de1;
            end
        end
    end

endmodule
`default_nettype wire
